// File: rtl/xrc_step_ctrl_pkg.sv
// Shared definitions for the x_rc step controller and related EKF stages.
package xrc_step_ctrl_pkg;

  localparam int unsigned DW_X_DEF = 24;
  localparam int unsigned DW_I_DEF = 5;

  localparam logic [23:0] Q123_MAX = 24'h7FFFFF;
  localparam logic [23:0] Q123_MIN = 24'h800000;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PRED = 2'd1,
    CORR = 2'd2
  } state_t;

endpackage

// File: rtl/xrc_step_ctrl_if.sv
// Bundle of sample, ALU and correction signals around the x_rc step controller.
interface xrc_step_ctrl_if #(
  parameter int unsigned DW_X = 24,
  parameter int unsigned DW_I = 5
);

  logic            smp_valid;
  logic [DW_I-1:0] smp_ib;
  logic            smp_ready;
  logic [DW_X-1:0] bef_x_rc;
  logic [DW_I-1:0] i_b;
  logic [DW_X-1:0] x_rc_p;
  logic            xp_valid;
  logic [DW_X-1:0] xp_out;
  logic            corr_valid;
  logic [DW_X-1:0] corr_dx;
  logic            corr_ready;
  logic [DW_X-1:0] x_rc;
  logic            upd_done;

  // Controller side
  modport master (
    input  smp_valid, smp_ib, x_rc_p, corr_valid, corr_dx,
    output smp_ready, bef_x_rc, i_b, xp_valid, xp_out, corr_ready, x_rc, upd_done
  );

  // Environment side: sample producer, prediction ALU, gain stage
  modport slave (
    output smp_valid, smp_ib, x_rc_p, corr_valid, corr_dx,
    input  smp_ready, bef_x_rc, i_b, xp_valid, xp_out, corr_ready, x_rc, upd_done
  );

endinterface

// File: rtl/xrc_step_ctrl_sat_add.sv
// Combinational saturating signed adder, clamps to the most positive/negative W-bit value.
module sat_add_q123
  import xrc_step_ctrl_pkg::*;
#(
  parameter int unsigned W = DW_X_DEF
) (
  input  logic [W-1:0] i_a,
  input  logic [W-1:0] i_b,
  output logic [W-1:0] o_sum
);

  logic [W:0] w_sum;

  // One guard bit: overflow shows as a disagreement between the top two sum bits
  always_comb begin
    w_sum = {i_a[W-1], i_a} + {i_b[W-1], i_b};
    if (w_sum[W] != w_sum[W-1]) begin
      o_sum = w_sum[W] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
    end else begin
      o_sum = w_sum[W-1:0];
    end
  end

endmodule

// File: rtl/xrc_step_ctrl.sv
// Per-sample sequencer and sole holder of the RC-branch state x_rc.
module xrc_step_ctrl
  import xrc_step_ctrl_pkg::*;
#(
  parameter int unsigned     DW_X    = DW_X_DEF,
  parameter int unsigned     DW_I    = DW_I_DEF,
  parameter int unsigned     ALU_LAT = 1,
  parameter logic [DW_X-1:0] X_INIT  = '0
) (
  input  logic           clk,
  input  logic           rst,
  xrc_step_ctrl_if.master bus
);

  state_t          r_state;
  state_t          w_state_nxt;
  logic [3:0]      r_cnt;
  logic [DW_I-1:0] r_ib;
  logic [DW_X-1:0] r_xp;
  logic [DW_X-1:0] r_x;
  logic            r_upd_done;
  logic            w_accept;
  logic            w_capture;
  logic            w_commit;
  logic [DW_X-1:0] w_sat;

  sat_add_q123 #(.W(DW_X)) u_sat (
    .i_a   (r_xp),
    .i_b   (bus.corr_dx),
    .o_sum (w_sat)
  );

  // Next-state decode and handshake outputs
  always_comb begin
    w_state_nxt    = r_state;
    w_accept       = 1'b0;
    w_capture      = 1'b0;
    w_commit       = 1'b0;
    bus.smp_ready  = 1'b0;
    bus.xp_valid   = 1'b0;
    bus.corr_ready = 1'b0;
    case (r_state)
      IDLE: begin
        bus.smp_ready = 1'b1;
        if (bus.smp_valid) begin
          w_accept    = 1'b1;
          w_state_nxt = PRED;
        end
      end
      PRED: begin
        if (r_cnt == 4'd0) begin
          w_capture   = 1'b1;
          w_state_nxt = CORR;
        end
      end
      CORR: begin
        bus.xp_valid   = 1'b1;
        bus.corr_ready = 1'b1;
        if (bus.corr_valid) begin
          w_commit    = 1'b1;
          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_nxt;
  end

  // ALU latency countdown, loaded on sample accept
  always_ff @(posedge clk) begin
    if (rst)                                r_cnt <= '0;
    else if (w_accept)                      r_cnt <= 4'(ALU_LAT);
    else if (r_state == PRED && r_cnt != 0) r_cnt <= r_cnt - 4'd1;
  end

  // Datapath: sample latch, prediction capture, state commit
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ib       <= '0;
      r_xp       <= '0;
      r_x        <= X_INIT;
      r_upd_done <= 1'b0;
    end else begin
      r_upd_done <= w_commit;
      if (w_accept)  r_ib <= bus.smp_ib;
      if (w_capture) r_xp <= bus.x_rc_p;
      if (w_commit)  r_x  <= w_sat;
    end
  end

  assign bus.i_b      = r_ib;
  assign bus.xp_out   = r_xp;
  assign bus.x_rc     = r_x;
  assign bus.bef_x_rc = r_x;
  assign bus.upd_done = r_upd_done;

endmodule

// File: tb/tb_xrc_step_ctrl.sv
// Directed bench for xrc_step_ctrl with a one-stage ALU stand-in.
module tb_xrc_step_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [23:0] tb_xp;
  int          n_assert = 0;
  int          n_fail   = 0;

  xrc_step_ctrl_if #(.DW_X(24), .DW_I(5)) bus ();

  xrc_step_ctrl #(
    .DW_X    (24),
    .DW_I    (5),
    .ALU_LAT (1),
    .X_INIT  (24'h000000)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Prediction ALU stand-in: one register stage returning the bench-chosen result
  always_ff @(posedge clk) bus.x_rc_p <= tb_xp;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One full step with corr_valid already high; checks each edge of the step
  task automatic step(input logic [4:0] ib, input logic [23:0] xp, input logic [23:0] dx,
                      input logic [23:0] exp_x);
    bus.smp_valid  = 1'b1;
    bus.smp_ib     = ib;
    tb_xp          = xp;
    bus.corr_valid = 1'b1;
    bus.corr_dx    = dx;
    tick();
    check("step_ib", 32'(bus.i_b), 32'(ib));
    check("step_rdy_busy", 32'(bus.smp_ready), 0);
    bus.smp_valid = 1'b0;
    tick();
    check("step_xpv_pred", 32'(bus.xp_valid), 0);
    tick();
    check("step_xpv", 32'(bus.xp_valid), 1);
    check("step_xp_out", 32'(bus.xp_out), 32'(xp));
    tick();
    check("step_x_rc", 32'(bus.x_rc), 32'(exp_x));
    check("step_bef", 32'(bus.bef_x_rc), 32'(exp_x));
    check("step_upd", 32'(bus.upd_done), 1);
    check("step_rdy_idle", 32'(bus.smp_ready), 1);
    bus.corr_valid = 1'b0;
    tick();
    check("step_upd_off", 32'(bus.upd_done), 0);
  endtask

  initial begin
    rst            = 1'b1;
    bus.smp_valid  = 1'b0;
    bus.smp_ib     = '0;
    bus.corr_valid = 1'b0;
    bus.corr_dx    = '0;
    tb_xp          = '0;

    // Reset state
    tick();
    tick();
    check("rst_x_rc", 32'(bus.x_rc), 0);
    check("rst_bef", 32'(bus.bef_x_rc), 0);
    check("rst_ib", 32'(bus.i_b), 0);
    check("rst_xp_out", 32'(bus.xp_out), 0);
    check("rst_rdy", 32'(bus.smp_ready), 1);
    check("rst_xpv", 32'(bus.xp_valid), 0);
    check("rst_upd", 32'(bus.upd_done), 0);
    check("rst_crdy", 32'(bus.corr_ready), 0);
    rst = 1'b0;
    tick();

    // Nominal step: 0x200000 + 0x010000
    step(5'h02, 24'h200000, 24'h010000, 24'h210000);
    // Positive and negative saturation, zero correction
    step(5'h03, 24'h7F0000, 24'h200000, 24'h7FFFFF);
    step(5'h1F, 24'h900000, 24'h900000, 24'h800000);
    step(5'h04, 24'h123456, 24'h000000, 24'h123456);
    // Small negative result without overflow
    step(5'h10, 24'h100000, 24'hE00000, 24'hF00000);

    // Busy back-pressure: smp_valid held high, smp_ib changing every cycle
    tb_xp          = 24'h020000;
    bus.corr_dx    = 24'h001000;
    bus.corr_valid = 1'b1;
    bus.smp_valid  = 1'b1;
    for (int s = 0; s < 3; s++) begin
      for (int c = 0; c < 4; c++) begin
        bus.smp_ib = 5'(4 * s + c + 1);
        tick();
        check("bp_ib", 32'(bus.i_b), 32'(4 * s + 1));
        check("bp_rdy", 32'(bus.smp_ready), (c == 3) ? 1 : 0);
        check("bp_upd", 32'(bus.upd_done), (c == 3) ? 1 : 0);
      end
    end
    check("bp_x_rc", 32'(bus.x_rc), 32'h021000);
    bus.smp_valid  = 1'b0;
    bus.corr_valid = 1'b0;
    tick();

    // Correction stall: corr_valid arrives 10 cycles after xp_valid
    bus.smp_valid = 1'b1;
    bus.smp_ib    = 5'h01;
    tb_xp         = 24'h050000;
    bus.corr_dx   = 24'h001000;
    tick();
    bus.smp_valid = 1'b0;
    tick();
    tick();
    check("st_xpv0", 32'(bus.xp_valid), 1);
    for (int i = 1; i < 10; i++) begin
      tick();
      check("st_xpv", 32'(bus.xp_valid), 1);
      check("st_crdy", 32'(bus.corr_ready), 1);
      check("st_x_rc", 32'(bus.x_rc), 32'h021000);
      check("st_xp_out", 32'(bus.xp_out), 32'h050000);
      check("st_upd", 32'(bus.upd_done), 0);
    end
    bus.corr_valid = 1'b1;
    tick();
    check("st_commit", 32'(bus.x_rc), 32'h051000);
    check("st_upd1", 32'(bus.upd_done), 1);
    // corr_valid left high in IDLE must be ignored
    for (int i = 0; i < 3; i++) begin
      tick();
      check("st_upd_once", 32'(bus.upd_done), 0);
      check("st_x_hold", 32'(bus.x_rc), 32'h051000);
    end

    // Reset mid-PRED abandons the step
    bus.smp_valid = 1'b1;
    bus.smp_ib    = 5'h09;
    tb_xp         = 24'h300000;
    bus.corr_dx   = 24'h000000;
    tick();
    bus.smp_valid = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("mr_rdy", 32'(bus.smp_ready), 1);
    check("mr_x_rc", 32'(bus.x_rc), 0);
    check("mr_ib", 32'(bus.i_b), 0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("mr_xpv", 32'(bus.xp_valid), 0);
      check("mr_upd", 32'(bus.upd_done), 0);
    end
    step(5'h09, 24'h300000, 24'h000000, 24'h300000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
